data_mem_responder: RTL and testbench

- Memory-side responder for CPU load/store traffic. Accepts one word request at a time over a valid/ready request channel and performs the read or write on an internal word-addressed RAM.
- Returns read data and a status on a valid/ready response channel after a programmable number of wait states.
- Replaces the zero-latency data memory when the core is moved to a handshaked memory interface.

---
 rtl/data_mem_responder.sv | 212 +++++++++++++++++++++
 tb/tb_data_mem_responder.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: memory-side responder for CPU load/store traffic.
// One word request is accepted at a time over a valid/ready request channel.
// The access runs against an internal word-addressed RAM. The response comes
// back on a valid/ready channel after WAIT_STATES extra cycles.
// Transaction flow: IDLE -> DECODE -> WAIT (WAIT_STATES cycles) -> EXEC -> RESP.
// DECODE registers the address check, so the subtract/compare stays off the
// RAM access path. It also sets the accept-to-response latency to 2+WAIT_STATES.
// Optional feature: define DATA_MEM_RESPONDER_STATS_EN to add read, write and
// error access counters as extra outputs.
module data_mem_responder #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
`ifdef DATA_MEM_RESPONDER_STATS_EN
    ,
    output logic [31:0] stat_reads,
    output logic [31:0] stat_writes,
    output logic [31:0] stat_errors
`endif
);

    localparam int unsigned IDX_W     = $clog2(DEPTH);
    localparam logic [31:0] DEPTH_W   = 32'(DEPTH);
    localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_WAIT,
        S_EXEC,
        S_RESP
    } state_t;

    state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    // Latched request; only meaningful between acceptance and EXEC
    logic             write_q, write_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       be_q, be_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             err_q, err_d;

    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_error_q, rsp_error_d;

    logic [31:0] mem_q [DEPTH];
    logic        mem_we;

    logic [29:0] word_off;
    logic        below_base;
    logic        misaligned;
    logic        out_of_range;

`ifdef DATA_MEM_RESPONDER_STATS_EN
    logic [31:0] stat_reads_q, stat_reads_d;
    logic [31:0] stat_writes_q, stat_writes_d;
    logic [31:0] stat_errors_q, stat_errors_d;
`endif

    // BASE_ADDR is DEPTH*4 aligned, so the word offset is a plain word subtract
    assign word_off     = addr_q[31:2] - BASE_ADDR[31:2];
    assign below_base   = (addr_q < BASE_ADDR);
    assign misaligned   = (addr_q[1:0] != 2'b00);
    assign out_of_range = ({2'b00, word_off} >= DEPTH_W);

    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;

`ifdef DATA_MEM_RESPONDER_STATS_EN
    assign stat_reads  = stat_reads_q;
    assign stat_writes = stat_writes_q;
    assign stat_errors = stat_errors_q;
`endif

    // Next-state, handshake outputs and request/response capture
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        idx_d       = idx_q;
        err_d       = err_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        mem_we      = 1'b0;
`ifdef DATA_MEM_RESPONDER_STATS_EN
        stat_reads_d  = stat_reads_q;
        stat_writes_d = stat_writes_q;
        stat_errors_d = stat_errors_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                idx_d   = word_off[IDX_W-1:0];
                err_d   = misaligned | below_base | out_of_range;
                cnt_d   = WAIT_LOAD;
                state_d = (WAIT_STATES > 0) ? S_WAIT : S_EXEC;
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_EXEC;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_EXEC: begin
                mem_we      = write_q & ~err_q;
                rsp_error_d = err_q;
                rsp_rdata_d = (err_q | write_q) ? 32'h0 : mem_q[idx_q];
`ifdef DATA_MEM_RESPONDER_STATS_EN
                if (err_q) begin
                    stat_errors_d = stat_errors_q + 32'd1;
                end else if (write_q) begin
                    stat_writes_d = stat_writes_q + 32'd1;
                end else begin
                    stat_reads_d = stat_reads_q + 32'd1;
                end
`endif
                state_d = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and response registers; cleared by the asynchronous reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            rsp_rdata_q <= 32'h0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    // Latched request and decode results; control decides when they matter
    always_ff @(posedge clk) begin
        write_q <= write_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        be_q    <= be_d;
        idx_q   <= idx_d;
        err_q   <= err_d;
    end

    // Byte-masked RAM write, committed at the EXEC edge; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

`ifdef DATA_MEM_RESPONDER_STATS_EN
    // Access counters; wrap naturally at 2^32
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_reads_q  <= 32'd0;
            stat_writes_q <= 32'd0;
            stat_errors_q <= 32'd0;
        end else begin
            stat_reads_q  <= stat_reads_d;
            stat_writes_q <= stat_writes_d;
            stat_errors_q <= stat_errors_d;
        end
    end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: a WAIT_STATES=2 instance (u_ws2) and a
// WAIT_STATES=0 instance (u_ws0) share the request buses. Expected responses
// are queued at request acceptance and compared when the response appears.
module tb_data_mem_responder;

    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sel;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_ready;

    logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_error;
    logic [31:0] a_rsp_rdata;
    logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_error;
    logic [31:0] b_rsp_rdata;
    logic        s_req_ready, s_rsp_valid, s_rsp_error;
    logic [31:0] s_rsp_rdata;
`ifdef DATA_MEM_RESPONDER_STATS_EN
    logic [31:0] a_stat_reads, a_stat_writes, a_stat_errors;
    logic [31:0] b_stat_reads, b_stat_writes, b_stat_errors;
`endif

    assign a_req_valid = req_valid & ~sel;
    assign b_req_valid = req_valid & sel;
    assign s_req_ready = sel ? b_req_ready : a_req_ready;
    assign s_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
    assign s_rsp_error = sel ? b_rsp_error : a_rsp_error;
    assign s_rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(2), .BASE_ADDR(32'h0)) u_ws2 (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(a_rsp_rdata), .rsp_error(a_rsp_error)
`ifdef DATA_MEM_RESPONDER_STATS_EN
        , .stat_reads(a_stat_reads), .stat_writes(a_stat_writes), .stat_errors(a_stat_errors)
`endif
    );

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_ws0 (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(b_rsp_rdata), .rsp_error(b_rsp_error)
`ifdef DATA_MEM_RESPONDER_STATS_EN
        , .stat_reads(b_stat_reads), .stat_writes(b_stat_writes), .stat_errors(b_stat_errors)
`endif
    );

    typedef struct {
        int          dut;
        logic        write;
        int          idx;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [2][DEPTH];
    int          checks   = 0;
    int          failures = 0;

    // Drive one request, wait for acceptance, queue its expected response
    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, output bit ok);
        exp_t e;
        int   n;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        n = 0;
        while (!s_req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = s_req_ready;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        e.dut   = sel ? 1 : 0;
        e.write = w;
        e.idx   = int'(a[11:2]);
        e.wdata = d;
        e.be    = be;
        e.err   = (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
        e.rdata = (w || e.err) ? 32'h0 : model[e.dut][e.idx];
        sb.push_back(e);
    endtask

    // Count edges from acceptance until rsp_valid is seen; -1 on timeout
    task automatic wait_rsp(output int lat);
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (s_rsp_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    // Retire the oldest expectation, applying committed stores to the model
    task automatic pop_exp(output exp_t e);
        e = sb.pop_front();
        if (e.write && !e.err) begin
            for (int i = 0; i < 4; i++) begin
                if (e.be[i]) model[e.dut][e.idx][8*i +: 8] = e.wdata[8*i +: 8];
            end
        end
    endtask

    // Full transaction with rsp_ready held high
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, output bit ok, output int lat,
                       output logic [31:0] got_rd, output logic got_err, output exp_t e);
        send(w, a, d, be, ok);
        wait_rsp(lat);
        got_rd  = s_rsp_rdata;
        got_err = s_rsp_error;
        pop_exp(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; sel = 1'b0; rsp_ready = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_be = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (a_req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", a_req_ready); end
        checks++; if (a_rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", a_rsp_valid); end
        checks++; if (a_rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rsp_rdata got=%h exp=0", a_rsp_rdata); end
        checks++; if (a_rsp_error !== 1'b0) begin failures++; $display("FAIL reset_rsp_error got=%b exp=0", a_rsp_error); end
        checks++; if (b_req_ready !== 1'b1) begin failures++; $display("FAIL reset_ws0_req_ready got=%b exp=1", b_req_ready); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic();
        bit ok; int lat; logic [31:0] rd; logic er; exp_t e;
        sel = 1'b0;
        txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, ok, lat, rd, er, e);
        checks++; if (!ok) begin failures++; $display("FAIL basic_store_accept got=0 exp=1"); end
        checks++; if (lat !== 4) begin failures++; $display("FAIL basic_store_latency got=%0d exp=4", lat); end
        checks++; if (rd !== 32'h0 || er !== 1'b0) begin failures++; $display("FAIL basic_store_rsp got=%h/%b exp=0/0", rd, er); end
        checks++; if (s_req_ready !== 1'b1 || s_rsp_valid !== 1'b0) begin failures++; $display("FAIL basic_back_to_idle got=%b/%b exp=1/0", s_req_ready, s_rsp_valid); end
        txn(1'b0, 32'h10, 32'h0, 4'h0, ok, lat, rd, er, e);
        checks++; if (lat !== 4) begin failures++; $display("FAIL basic_load_latency got=%0d exp=4", lat); end
        checks++; if (rd !== 32'hDEADBEEF || rd !== e.rdata) begin failures++; $display("FAIL basic_load_data got=%h exp=%h", rd, 32'hDEADBEEF); end
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL basic_load_error got=%b exp=0", er); end
    endtask

    task automatic test_byte_enables();
        bit ok; int lat; logic [31:0] rd; logic er; exp_t e;
        sel = 1'b0;
        txn(1'b1, 32'h20, 32'h11223344, 4'hF, ok, lat, rd, er, e);
        txn(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, ok, lat, rd, er, e);
        txn(1'b0, 32'h20, 32'h0, 4'h0, ok, lat, rd, er, e);
        checks++; if (rd !== 32'h11BB33DD) begin failures++; $display("FAIL be_merge got=%h exp=11bb33dd", rd); end
        txn(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, ok, lat, rd, er, e);
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL be_zero_error got=%b exp=0", er); end
        txn(1'b0, 32'h20, 32'h0, 4'hF, ok, lat, rd, er, e);
        checks++; if (rd !== 32'h11BB33DD || rd !== e.rdata) begin failures++; $display("FAIL be_zero_nochange got=%h exp=11bb33dd", rd); end
    endtask

    task automatic test_errors();
        bit ok; int lat; logic [31:0] rd; logic er; exp_t e;
        sel = 1'b0;
        txn(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, ok, lat, rd, er, e);
        txn(1'b0, 32'h22, 32'h0, 4'hF, ok, lat, rd, er, e);
        checks++; if (er !== 1'b1) begin failures++; $display("FAIL err_misaligned_flag got=%b exp=1", er); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL err_misaligned_rdata got=%h exp=0", rd); end
        checks++; if (lat !== 4) begin failures++; $display("FAIL err_misaligned_latency got=%0d exp=4", lat); end
        txn(1'b1, 32'h1000, 32'h0BADBEEF, 4'hF, ok, lat, rd, er, e);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL err_range_store got=%h/%b exp=0/1", rd, er); end
        txn(1'b0, 32'h0, 32'h0, 4'hF, ok, lat, rd, er, e);
        checks++; if (rd !== 32'hCAFEF00D || er !== 1'b0) begin failures++; $display("FAIL err_no_side_effect got=%h/%b exp=cafef00d/0", rd, er); end
    endtask

    task automatic test_backpressure();
        bit ok; int lat; logic [31:0] rd; logic er; logic [31:0] rd0; logic er0; exp_t e;
        sel = 1'b0;
        rsp_ready = 1'b0;
        send(1'b0, 32'h10, 32'h0, 4'hF, ok);
        wait_rsp(lat);
        checks++; if (lat !== 4) begin failures++; $display("FAIL bp_latency got=%0d exp=4", lat); end
        rd0 = s_rsp_rdata;
        er0 = s_rsp_error;
        // A store presented while busy must be ignored
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_be = 4'hF;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (s_rsp_valid !== 1'b1 || s_rsp_rdata !== rd0 || s_rsp_error !== er0 || s_req_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got v=%b d=%h e=%b rdy=%b exp v=1 d=%h e=%b rdy=0",
                         c, s_rsp_valid, s_rsp_rdata, s_rsp_error, s_req_ready, rd0, er0);
            end
        end
        req_valid = 1'b0;
        pop_exp(e);
        checks++; if (rd0 !== e.rdata || er0 !== 1'b0) begin failures++; $display("FAIL bp_data got=%h/%b exp=%h/0", rd0, er0, e.rdata); end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (s_req_ready !== 1'b1 || s_rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_release got=%b/%b exp=1/0", s_req_ready, s_rsp_valid); end
        txn(1'b0, 32'h10, 32'h0, 4'hF, ok, lat, rd, er, e);
        checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL bp_ignored_store got=%h exp=deadbeef", rd); end
    endtask

    task automatic test_reset_wait();
        bit ok; int lat; logic [31:0] rd; logic er; exp_t e;
        sel = 1'b0;
        txn(1'b1, 32'h40, 32'h12345678, 4'hF, ok, lat, rd, er, e);
        send(1'b1, 32'h40, 32'h00000055, 4'hF, ok);
        // Accepted; two more edges put the responder in its last WAIT cycle
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++; if (a_req_ready !== 1'b1) begin failures++; $display("FAIL rstwait_req_ready got=%b exp=1", a_req_ready); end
        checks++; if (a_rsp_valid !== 1'b0 || a_rsp_rdata !== 32'h0 || a_rsp_error !== 1'b0) begin
            failures++; $display("FAIL rstwait_outputs got=%b/%h/%b exp=0/0/0", a_rsp_valid, a_rsp_rdata, a_rsp_error);
        end
        void'(sb.pop_back());
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        txn(1'b0, 32'h40, 32'h0, 4'hF, ok, lat, rd, er, e);
        checks++; if (rd !== 32'h12345678 || rd !== e.rdata) begin failures++; $display("FAIL rstwait_not_committed got=%h exp=12345678", rd); end
    endtask

    task automatic test_zero_wait();
        bit ok; int lat; logic [31:0] rd; logic er; exp_t e;
        logic        w_t [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [31:0] a_t [6] = '{32'h0, 32'h4, 32'h0, 32'h4, 32'h0, 32'h3};
        logic [31:0] d_t [6] = '{32'hA1A1A1A1, 32'hB2B2B2B2, 32'h0, 32'h0, 32'h0, 32'h0};
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        sel = 1'b1;
        for (int i = 0; i < 6; i++) begin
            txn(w_t[i], a_t[i], d_t[i], 4'hF, ok, lat, rd, er, e);
            checks++;
            if (lat !== 2 || rd !== e.rdata || er !== e.err) begin
                failures++;
                $display("FAIL ws0_txn%0d got lat=%0d d=%h e=%b exp lat=2 d=%h e=%b", i, lat, rd, er, e.rdata, e.err);
            end
        end
        checks++; if (b_rsp_error !== 1'b1) begin failures++; $display("FAIL ws0_last_error got=%b exp=1", b_rsp_error); end
`ifdef DATA_MEM_RESPONDER_STATS_EN
        checks++; if (b_stat_reads !== 32'd3) begin failures++; $display("FAIL stat_reads got=%0d exp=3", b_stat_reads); end
        checks++; if (b_stat_writes !== 32'd2) begin failures++; $display("FAIL stat_writes got=%0d exp=2", b_stat_writes); end
        checks++; if (b_stat_errors !== 32'd1) begin failures++; $display("FAIL stat_errors got=%0d exp=1", b_stat_errors); end
`endif
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_byte_enables();
        test_errors();
        test_backpressure();
        test_reset_wait();
        test_zero_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
